term_ctrl: RTL and testbench

Text-terminal write controller for the character video memory. Accepts ASCII bytes from the PS/2 decoder over a valid/ready handshake and tracks a cursor. Issues single-byte writes into the 70×30 character RAM and performs line wrap, backspace, scrolling via a circular row offset, and clear-screen after reset. The VGA side adds `top_row` to its display row to read the scrolled view.

---
 rtl/term_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_term_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/term_ctrl.sv
// term_ctrl: text-terminal write controller for the character video RAM.
// Takes ASCII bytes over valid/ready, tracks a cursor, and issues one
// character-RAM write per cycle. Scrolling moves a circular top_row offset
// and blanks the row that scrolls off. A full-screen clear runs after reset.
module term_ctrl #(
  parameter int         COLS  = 70,
  parameter int         ROWS  = 30,
  parameter logic [7:0] BLANK = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  key_in,
  input  logic        key_valid,
  output logic        key_ready,
  output logic        mem_we,
  output logic [11:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic [4:0]  top_row,
  output logic [6:0]  cur_x,
  output logic [4:0]  cur_y,
  output logic        busy
);

  typedef enum logic [1:0] {CLR_ALL, IDLE, POST, CLR_LINE} state_t;

  localparam logic [6:0] LAST_X = 7'(COLS - 1);
  localparam logic [4:0] LAST_Y = 5'(ROWS - 1);
  localparam logic [5:0] ROWS6  = 6'(ROWS);
  localparam logic [7:0] COLS8  = 8'(COLS);

  state_t      state_q, state_d;
  logic [6:0]  cur_x_q, cur_x_d;
  logic [4:0]  cur_y_q, cur_y_d;
  logic [4:0]  top_row_q, top_row_d;
  logic [4:0]  clr_row_q, clr_row_d;
  logic        scroll_q, scroll_d;
  logic [7:0]  col_cnt_q, col_cnt_d;   // column counter for both clears
  logic [5:0]  row_cnt_q, row_cnt_d;   // row counter for CLR_ALL; ROWS means done
  logic        mem_we_q, mem_we_d;
  logic [11:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        key_ready_q, key_ready_d;
  logic        busy_q, busy_d;

  logic [5:0]  psum, pdiff;
  logic [4:0]  phys_row, prev_phys;
  logic        nl;

  // Physical row of the cursor line and of the line above it (circular).
  always_comb begin
    psum      = {1'b0, cur_y_q} + {1'b0, top_row_q};
    pdiff     = psum - ROWS6;
    phys_row  = (psum >= ROWS6) ? pdiff[4:0] : psum[4:0];
    prev_phys = (phys_row == 5'd0) ? LAST_Y : phys_row - 5'd1;
  end

  // Next-state, cursor, scroll and write-port decisions.
  always_comb begin
    state_d     = state_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    top_row_d   = top_row_q;
    clr_row_d   = clr_row_q;
    scroll_d    = scroll_q;
    col_cnt_d   = col_cnt_q;
    row_cnt_d   = row_cnt_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    nl          = 1'b0;
    case (state_q)
      CLR_ALL: begin
        if (row_cnt_q < ROWS6) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = {col_cnt_q[6:0], row_cnt_q[4:0]};
          mem_wdata_d = BLANK;
          if (col_cnt_q == COLS8 - 8'd1) begin
            col_cnt_d = 8'd0;
            row_cnt_d = row_cnt_q + 6'd1;
          end else begin
            col_cnt_d = col_cnt_q + 8'd1;
          end
        end else begin
          state_d   = IDLE;
          col_cnt_d = 8'd0;
        end
      end
      IDLE: begin
        if (key_valid) begin
          state_d = POST;
          if (key_in >= 8'h20 && key_in <= 8'h7E) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = {cur_x_q, phys_row};
            mem_wdata_d = key_in;
            if (cur_x_q < LAST_X) cur_x_d = cur_x_q + 7'd1;
            else                  nl      = 1'b1;
          end else if (key_in == 8'h0A || key_in == 8'h0D) begin
            nl = 1'b1;
          end else if (key_in == 8'h08) begin
            if (cur_x_q != 7'd0) begin
              cur_x_d     = cur_x_q - 7'd1;
              mem_we_d    = 1'b1;
              mem_addr_d  = {cur_x_q - 7'd1, phys_row};
              mem_wdata_d = BLANK;
            end else if (cur_y_q != 5'd0) begin
              cur_x_d     = LAST_X;
              cur_y_d     = cur_y_q - 5'd1;
              mem_we_d    = 1'b1;
              mem_addr_d  = {LAST_X, prev_phys};
              mem_wdata_d = BLANK;
            end
          end
          if (nl) begin
            cur_x_d = 7'd0;
            if (cur_y_q < LAST_Y) begin
              cur_y_d = cur_y_q + 5'd1;
            end else begin
              // Old top line scrolls off; it becomes the new bottom line.
              top_row_d = (top_row_q == LAST_Y) ? 5'd0 : top_row_q + 5'd1;
              clr_row_d = top_row_q;
              scroll_d  = 1'b1;
            end
          end
        end
      end
      POST: begin
        if (scroll_q) begin
          // Column 0 of the line clear goes out straight from POST.
          scroll_d    = 1'b0;
          state_d     = CLR_LINE;
          mem_we_d    = 1'b1;
          mem_addr_d  = {7'd0, clr_row_q};
          mem_wdata_d = BLANK;
          col_cnt_d   = 8'd1;
        end else begin
          state_d = IDLE;
        end
      end
      CLR_LINE: begin
        if (col_cnt_q < COLS8) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = {col_cnt_q[6:0], clr_row_q};
          mem_wdata_d = BLANK;
          col_cnt_d   = col_cnt_q + 8'd1;
        end else begin
          state_d   = IDLE;
          col_cnt_d = 8'd0;
        end
      end
      default: state_d = CLR_ALL;
    endcase
    key_ready_d = (state_d == IDLE);
    busy_d      = (state_d == CLR_ALL) || (state_d == CLR_LINE);
  end

  // State and registered outputs; reset restarts the full clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= CLR_ALL;
      cur_x_q     <= 7'd0;
      cur_y_q     <= 5'd0;
      top_row_q   <= 5'd0;
      clr_row_q   <= 5'd0;
      scroll_q    <= 1'b0;
      col_cnt_q   <= 8'd0;
      row_cnt_q   <= 6'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 12'd0;
      mem_wdata_q <= 8'd0;
      key_ready_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      top_row_q   <= top_row_d;
      clr_row_q   <= clr_row_d;
      scroll_q    <= scroll_d;
      col_cnt_q   <= col_cnt_d;
      row_cnt_q   <= row_cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      key_ready_q <= key_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign key_ready = key_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign top_row   = top_row_q;
  assign cur_x     = cur_x_q;
  assign cur_y     = cur_y_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_term_ctrl.sv
// Directed bench for term_ctrl: clear after reset, printing, wrap,
// backspace, scrolling and reset in the middle of a line clear.
module tb_term_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  key_in = 8'h00;
  logic        key_valid = 1'b0;
  logic        key_ready, mem_we, busy;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [4:0]  top_row, cur_y;
  logic [6:0]  cur_x;

  int nvec = 0;
  int nerr = 0;

  term_ctrl dut (
    .clk(clk), .reset(reset), .key_in(key_in), .key_valid(key_valid),
    .key_ready(key_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .top_row(top_row), .cur_x(cur_x), .cur_y(cur_y),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Advance one cycle; outputs are observed and inputs driven at negedge.
  task automatic cyc();
    @(negedge clk);
  endtask

  // Present one byte; returns in the cycle after the accepting edge.
  task automatic send_key(input logic [7:0] k);
    int t = 0;
    while (!key_ready && t < 200) begin cyc(); t++; end
    if (t == 200) begin
      nvec++; nerr++;
      $display("FAIL key_ready_wait: key_ready=%b after %0d cycles, need 1", key_ready, t);
    end
    key_in = k;
    key_valid = 1'b1;
    cyc();
    key_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) cyc();
    nvec++;
    if ({mem_we, mem_addr, mem_wdata, cur_x, cur_y, top_row, key_ready, busy} !==
        {1'b0, 12'd0, 8'd0, 7'd0, 5'd0, 5'd0, 1'b0, 1'b1}) begin
      nerr++;
      $display("FAIL reset_vals: we=%b addr=%h wd=%h x=%0d y=%0d top=%0d rdy=%b busy=%b, need 0 0 0 0 0 0 0 1",
               mem_we, mem_addr, mem_wdata, cur_x, cur_y, top_row, key_ready, busy);
    end
  endtask

  // Release reset and check the 2100-cycle full clear.
  task automatic test_clear_all();
    bit seen [0:4095];
    int good = 0, dup = 0;
    logic first_ok;
    for (int a = 0; a < 4096; a++) seen[a] = 1'b0;
    reset = 1'b0;
    for (int k = 1; k <= 2100; k++) begin
      cyc();
      if (k == 1) first_ok = mem_we && (mem_addr == 12'd0);
      if (mem_we === 1'b1 && mem_wdata === 8'h00 &&
          mem_addr[11:5] < 7'd70 && mem_addr[4:0] < 5'd30) begin
        if (seen[mem_addr]) dup++;
        seen[mem_addr] = 1'b1;
        good++;
      end
      if (k == 2100) begin
        nvec++;
        if (key_ready !== 1'b0 || busy !== 1'b1) begin
          nerr++;
          $display("FAIL clr_last_cycle: rdy=%b busy=%b, need 0 1", key_ready, busy);
        end
      end
    end
    nvec++;
    if (first_ok !== 1'b1) begin
      nerr++; $display("FAIL clr_first: first write not at cycle 1 addr 0");
    end
    nvec++;
    if (good != 2100 || dup != 0) begin
      nerr++; $display("FAIL clr_count: good=%0d dup=%0d, need 2100 0", good, dup);
    end
    cyc();
    nvec++;
    if (key_ready !== 1'b1 || busy !== 1'b0 || mem_we !== 1'b0) begin
      nerr++;
      $display("FAIL clr_done: rdy=%b busy=%b we=%b, need 1 0 0", key_ready, busy, mem_we);
    end
  endtask

  task automatic test_single_a();
    send_key(8'h41);
    nvec++;
    if ({mem_we, mem_addr, mem_wdata, cur_x, cur_y, key_ready} !==
        {1'b1, 12'h000, 8'h41, 7'd1, 5'd0, 1'b0}) begin
      nerr++;
      $display("FAIL char_a: we=%b addr=%h wd=%h x=%0d y=%0d rdy=%b, need 1 000 41 1 0 0",
               mem_we, mem_addr, mem_wdata, cur_x, cur_y, key_ready);
    end
    cyc();
    nvec++;
    if (mem_we !== 1'b0 || key_ready !== 1'b1) begin
      nerr++; $display("FAIL char_a_after: we=%b rdy=%b, need 0 1", mem_we, key_ready);
    end
  endtask

  task automatic test_backspace_origin();
    send_key(8'h08);  // (1,0) -> (0,0)
    nvec++;
    if ({mem_we, mem_addr, mem_wdata, cur_x, cur_y} !== {1'b1, 12'h000, 8'h00, 7'd0, 5'd0}) begin
      nerr++;
      $display("FAIL bs_simple: we=%b addr=%h wd=%h x=%0d y=%0d, need 1 000 00 0 0",
               mem_we, mem_addr, mem_wdata, cur_x, cur_y);
    end
    send_key(8'h08);  // at origin: nothing
    nvec++;
    if ({mem_we, cur_x, cur_y, key_ready} !== {1'b0, 7'd0, 5'd0, 1'b0}) begin
      nerr++;
      $display("FAIL bs_origin: we=%b x=%0d y=%0d rdy=%b, need 0 0 0 0", mem_we, cur_x, cur_y, key_ready);
    end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    logic [7:0] ch;
    for (int i = 0; i < 70; i++) begin
      ch = 8'h21 + 8'(i);
      send_key(ch);
      if (mem_we !== 1'b1 || mem_addr !== {7'(i), 5'd0} || mem_wdata !== ch) bad++;
    end
    nvec++;
    if (bad != 0) begin
      nerr++; $display("FAIL b2b_writes: %0d bad writes, need 0", bad);
    end
    nvec++;
    if (cur_x !== 7'd0 || cur_y !== 5'd1) begin
      nerr++; $display("FAIL b2b_wrap: x=%0d y=%0d, need 0 1", cur_x, cur_y);
    end
  endtask

  task automatic test_backspace_wrap();
    int bad = 0;
    send_key(8'h08);
    nvec++;
    if ({mem_we, mem_addr, mem_wdata, cur_x, cur_y} !== {1'b1, 7'd69, 5'd0, 8'h00, 7'd69, 5'd0}) begin
      nerr++;
      $display("FAIL bs_wrap: we=%b addr=%h wd=%h x=%0d y=%0d, need 1 8a0 00 69 0",
               mem_we, mem_addr, mem_wdata, cur_x, cur_y);
    end
    for (int i = 68; i >= 0; i--) begin
      send_key(8'h08);
      if (mem_we !== 1'b1 || mem_addr !== {7'(i), 5'd0}) bad++;
    end
    nvec++;
    if (bad != 0 || cur_x !== 7'd0 || cur_y !== 5'd0) begin
      nerr++; $display("FAIL bs_run: bad=%0d x=%0d y=%0d, need 0 0 0", bad, cur_x, cur_y);
    end
  endtask

  task automatic test_scroll();
    int bad = 0;
    for (int i = 0; i < 29; i++) begin
      send_key((i % 2) ? 8'h0A : 8'h0D);
      if (mem_we !== 1'b0) bad++;
    end
    nvec++;
    if (bad != 0 || cur_y !== 5'd29 || top_row !== 5'd0) begin
      nerr++; $display("FAIL enter_29: writes=%0d y=%0d top=%0d, need 0 29 0", bad, cur_y, top_row);
    end
    send_key(8'h0A);
    nvec++;
    if ({mem_we, top_row, cur_x, cur_y, key_ready} !== {1'b0, 5'd1, 7'd0, 5'd29, 1'b0}) begin
      nerr++;
      $display("FAIL scroll_post: we=%b top=%0d x=%0d y=%0d rdy=%b, need 0 1 0 29 0",
               mem_we, top_row, cur_x, cur_y, key_ready);
    end
    bad = 0;
    for (int c = 0; c < 70; c++) begin
      cyc();
      if (mem_we !== 1'b1 || mem_addr !== {7'(c), 5'd0} || mem_wdata !== 8'h00 || key_ready !== 1'b0) bad++;
    end
    nvec++;
    if (bad != 0) begin
      nerr++; $display("FAIL scroll_clear: %0d bad clear cycles, need 0", bad);
    end
    cyc();
    nvec++;
    if (mem_we !== 1'b0 || key_ready !== 1'b1 || busy !== 1'b0) begin
      nerr++; $display("FAIL scroll_end: we=%b rdy=%b busy=%b, need 0 1 0", mem_we, key_ready, busy);
    end
    send_key(8'h42);
    nvec++;
    if ({mem_we, mem_addr, mem_wdata, cur_x, cur_y} !== {1'b1, 12'h000, 8'h42, 7'd1, 5'd29}) begin
      nerr++;
      $display("FAIL char_b: we=%b addr=%h wd=%h x=%0d y=%0d, need 1 000 42 1 29",
               mem_we, mem_addr, mem_wdata, cur_x, cur_y);
    end
  endtask

  task automatic test_ignored();
    send_key(8'h1B);
    nvec++;
    if ({mem_we, cur_x, cur_y, top_row} !== {1'b0, 7'd1, 5'd29, 5'd1}) begin
      nerr++;
      $display("FAIL ignored: we=%b x=%0d y=%0d top=%0d, need 0 1 29 1", mem_we, cur_x, cur_y, top_row);
    end
  endtask

  task automatic test_reset_mid_clr_line();
    send_key(8'h0D);  // scroll again: top 1->2, clear phys row 1
    cyc();
    nvec++;
    if (mem_we !== 1'b1 || mem_addr !== {7'd0, 5'd1} || top_row !== 5'd2) begin
      nerr++;
      $display("FAIL scroll2_start: we=%b addr=%h top=%0d, need 1 001 2", mem_we, mem_addr, top_row);
    end
    repeat (3) cyc();
    reset = 1'b1;
    cyc();
    nvec++;
    if ({mem_we, mem_addr, top_row, cur_x, cur_y, key_ready, busy} !==
        {1'b0, 12'd0, 5'd0, 7'd0, 5'd0, 1'b0, 1'b1}) begin
      nerr++;
      $display("FAIL reset_mid_clr: we=%b addr=%h top=%0d x=%0d y=%0d rdy=%b busy=%b, need 0 000 0 0 0 0 1",
               mem_we, mem_addr, top_row, cur_x, cur_y, key_ready, busy);
    end
    cyc();
    test_clear_all();
  endtask

  initial begin
    test_reset();
    test_clear_all();
    test_single_a();
    test_backspace_origin();
    test_back_to_back();
    test_backspace_wrap();
    test_scroll();
    test_ignored();
    test_reset_mid_clr_line();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
